// File: rtl/router_pkg.sv
// Shared router types: port count, port index type and switch-allocator FSM states.
package router_pkg;

  localparam int unsigned NUM_PORTS = 5;

  typedef logic [$clog2(NUM_PORTS)-1:0] PORT_IDX_t;

  typedef enum logic {
    SA_IDLE   = 1'b0,
    SA_ACTIVE = 1'b1
  } sa_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after prio, wrapping at N-1,
// wins.
module rr_arbiter #(
  parameter  int unsigned N = 5,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] prio,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);

  always_comb begin
    int unsigned j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(prio) + k;
      if (j >= N) j -= N;
      if (grant == '0 && req[j[W-1:0]]) begin
        grant[j[W-1:0]] = 1'b1;
        grant_idx       = j[W-1:0];
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Packet-locked switch allocator: one IDLE/ACTIVE FSM per output port, each with its own
// round-robin arbiter over the inputs that currently route to it.
module switch_allocator
  import router_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = router_pkg::NUM_PORTS,
  localparam int unsigned PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_PORTS-1:0]              i_req_valid,
  input  logic [NUM_PORTS-1:0][PORT_W-1:0]  i_req_port,
  input  logic [NUM_PORTS-1:0]              i_req_tail,
  input  logic [NUM_PORTS-1:0]              i_out_ready,
  input  logic [NUM_PORTS-1:0]              i_switch_ack,
  output logic [NUM_PORTS-1:0]              o_switch_req,
  output logic [NUM_PORTS-1:0][PORT_W-1:0]  o_xbar_sel,
  output logic [NUM_PORTS-1:0]              o_in_grant,
  output logic [NUM_PORTS-1:0]              o_flit_pop
);

  logic [NUM_PORTS-1:0]             active;
  logic [NUM_PORTS-1:0]             xfer;
  logic [NUM_PORTS-1:0][PORT_W-1:0] owner_vec;

  // Ownership and pops are folded back from the per-output owners to the inputs.
  always_comb begin
    o_in_grant = '0;
    o_flit_pop = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      if (active[o]) o_in_grant[owner_vec[o]] = 1'b1;
      if (xfer[o])   o_flit_pop[owner_vec[o]] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
    sa_state_t            state_q, state_d;
    logic [PORT_W-1:0]    owner_q, owner_d;
    logic [PORT_W-1:0]    prio_q, prio_d;
    logic [NUM_PORTS-1:0] cand;
    logic [NUM_PORTS-1:0] arb_grant;
    logic [PORT_W-1:0]    arb_idx;
    logic                 sw_req;

    // Inputs already holding an output are excluded so an input never owns two outputs.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cand
      assign cand[i] = i_req_valid[i] && (i_req_port[i] == PORT_W'(g)) && !o_in_grant[i];
    end

    rr_arbiter #(
      .N(NUM_PORTS)
    ) u_arb (
      .req       (cand),
      .prio      (prio_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
    );

    assign sw_req          = (state_q == SA_ACTIVE) && i_out_ready[g] && i_req_valid[owner_q];
    assign active[g]       = (state_q == SA_ACTIVE);
    assign xfer[g]         = sw_req && i_switch_ack[g];
    assign owner_vec[g]    = owner_q;
    assign o_switch_req[g] = sw_req;
    assign o_xbar_sel[g]   = (state_q == SA_ACTIVE) ? owner_q : '0;

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      prio_d  = prio_q;
      unique case (state_q)
        SA_IDLE: begin
          if ((arb_grant != '0) && i_out_ready[g]) begin
            state_d = SA_ACTIVE;
            owner_d = arb_idx;
          end
        end
        SA_ACTIVE: begin
          // Lock is held until the tail flit actually crosses the switch.
          if (xfer[g] && i_req_tail[owner_q]) begin
            state_d = SA_IDLE;
            prio_d  = (owner_q == PORT_W'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;
          end
        end
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= SA_IDLE;
        owner_q <= '0;
        prio_q  <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        prio_q  <= prio_d;
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural ownership model.
module tb_switch_allocator;

  localparam int NP = 5;
  localparam int PW = 3;

  logic                  clk;
  logic                  reset_n;
  logic [NP-1:0]         req_valid;
  logic [NP-1:0][PW-1:0] req_port;
  logic [NP-1:0]         req_tail;
  logic [NP-1:0]         out_ready;
  logic [NP-1:0]         switch_ack;
  logic [NP-1:0]         sreq;
  logic [NP-1:0][PW-1:0] sel;
  logic [NP-1:0]         ing;
  logic [NP-1:0]         pop;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: owner of each output (-1 = free) and its round-robin start point.
  int m_owner [NP] = '{default: -1};
  int m_prio  [NP] = '{default: 0};

  switch_allocator #(
    .NUM_PORTS(NP)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_req_valid  (req_valid),
    .i_req_port   (req_port),
    .i_req_tail   (req_tail),
    .i_out_ready  (out_ready),
    .i_switch_ack (switch_ack),
    .o_switch_req (sreq),
    .o_xbar_sel   (sel),
    .o_in_grant   (ing),
    .o_flit_pop   (pop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr();
    req_valid  = '0;
    req_port   = '0;
    req_tail   = '0;
    out_ready  = '0;
    switch_ack = '0;
  endtask

  task automatic do_reset();
    clr();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  // Per-cycle reference check, sampled mid-cycle.
  always @(negedge clk) begin : cmp
    logic [NP-1:0]         e_req, e_grant, e_pop;
    logic [NP-1:0][PW-1:0] e_sel;
    int n_owner [NP];
    int n_prio  [NP];
    int w, idx, cand;
    e_req   = '0;
    e_grant = '0;
    e_pop   = '0;
    e_sel   = '0;
    if (!reset_n) begin
      for (int o = 0; o < NP; o++) begin
        m_owner[o] = -1;
        m_prio[o]  = 0;
      end
    end else begin
      for (int o = 0; o < NP; o++) if (m_owner[o] >= 0) e_grant[m_owner[o]] = 1'b1;
      for (int o = 0; o < NP; o++) begin
        n_owner[o] = m_owner[o];
        n_prio[o]  = m_prio[o];
        if (m_owner[o] >= 0) begin
          w        = m_owner[o];
          e_sel[o] = PW'(w);
          e_req[o] = out_ready[o] & req_valid[w];
          if (e_req[o] && switch_ack[o]) begin
            e_pop[w] = 1'b1;
            if (req_tail[w]) begin
              n_owner[o] = -1;
              n_prio[o]  = (w + 1) % NP;
            end
          end
        end else if (out_ready[o]) begin
          cand = -1;
          for (int k = 0; k < NP; k++) begin
            idx = (m_prio[o] + k) % NP;
            if (cand < 0 && req_valid[idx] && int'(req_port[idx]) == o && !e_grant[idx])
              cand = idx;
          end
          n_owner[o] = cand;
        end
      end
      for (int o = 0; o < NP; o++) begin
        m_owner[o] = n_owner[o];
        m_prio[o]  = n_prio[o];
      end
    end
    check("cyc.switch_req", 32'(sreq), 32'(e_req));
    check("cyc.xbar_sel", 32'(sel), 32'(e_sel));
    check("cyc.in_grant", 32'(ing), 32'(e_grant));
    check("cyc.flit_pop", 32'(pop), 32'(e_pop));
  end

  initial begin
    clr();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;

    // Single 3-flit packet, input 1 -> output 2, then prio[2]=2 makes input 3 beat input 1.
    do_reset();
    out_ready = '1; switch_ack = '1;
    req_valid = 5'b00010; req_port[1] = 3'd2;
    settle(); check("A.lat_req", 32'(sreq), 0); check("A.lat_grant", 32'(ing), 0); step();
    settle();
    check("A.sel2", 32'(sel[2]), 1);
    check("A.req", 32'(sreq), 32'b00100);
    check("A.pop1", 32'(pop), 32'b00010);
    step();
    settle(); check("A.pop2", 32'(pop), 32'b00010); step();
    req_tail[1] = 1'b1;
    settle(); check("A.pop3", 32'(pop), 32'b00010); step();
    req_valid = '0; req_tail = '0;
    settle(); check("A.idle_grant", 32'(ing), 0); check("A.idle_req", 32'(sreq), 0); step();
    req_valid = 5'b01010; req_port[3] = 3'd2; req_tail = '1;
    settle(); step();
    settle(); check("A.prio_win", 32'(sel[2]), 3); step();
    req_valid = 5'b00010;
    settle(); check("A.gap", 32'(sreq), 0); step();
    settle(); check("A.next", 32'(sel[2]), 1); step();
    clr();

    // Contention on output 1: service order 0, 3, 4 with one idle cycle between.
    do_reset();
    out_ready = '1; switch_ack = '1; req_tail = '1;
    req_valid = 5'b11001; req_port[0] = 3'd1; req_port[3] = 3'd1; req_port[4] = 3'd1;
    settle(); step();
    settle(); check("B.first", 32'(sel[1]), 0); check("B.pop0", 32'(pop), 32'b00001); step();
    req_valid = 5'b11000;
    settle(); check("B.gap1", 32'(sreq), 0); step();
    settle(); check("B.second", 32'(sel[1]), 3); check("B.pop3", 32'(pop), 32'b01000); step();
    req_valid = 5'b10000;
    settle(); check("B.gap2", 32'(sreq), 0); step();
    settle(); check("B.third", 32'(sel[1]), 4); check("B.pop4", 32'(pop), 32'b10000); step();
    clr();

    // Packet lock: input 2 keeps output 0 through 4 not-ready cycles while input 3 waits.
    do_reset();
    out_ready = '1; switch_ack = '1;
    req_valid = 5'b01100; req_port[2] = 3'd0; req_port[3] = 3'd0;
    settle(); step();
    settle(); check("C.owner", 32'(sel[0]), 2); check("C.pop", 32'(pop), 32'b00100); step();
    out_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("C.lock_req", 32'(sreq[0]), 0);
      check("C.lock_owner", 32'(sel[0]), 2);
      check("C.lock_pop", 32'(pop), 0);
      step();
    end
    out_ready[0] = 1'b1; req_tail[2] = 1'b1;
    settle(); check("C.resume", 32'(sreq[0]), 1); check("C.tail_pop", 32'(pop), 32'b00100);
    step();
    req_valid = 5'b01000;
    settle(); check("C.gap", 32'(ing), 0); step();
    settle(); check("C.next", 32'(sel[0]), 3); step();
    clr();

    // Parallel grants: 0->3 and 1->4 in the same cycle, popped independently.
    do_reset();
    out_ready = '1; switch_ack = '1;
    req_valid = 5'b00011; req_port[0] = 3'd3; req_port[1] = 3'd4;
    settle(); step();
    switch_ack = 5'b01000;
    settle();
    check("D.req", 32'(sreq), 32'b11000);
    check("D.sel3", 32'(sel[3]), 0);
    check("D.sel4", 32'(sel[4]), 1);
    check("D.grant", 32'(ing), 32'b00011);
    check("D.pop_a", 32'(pop), 32'b00001);
    step();
    switch_ack = 5'b10000; req_tail = '1;
    settle(); check("D.pop_b", 32'(pop), 32'b00010); step();
    switch_ack = '1;
    settle(); check("D.grant2", 32'(ing), 32'b00001); check("D.pop_c", 32'(pop), 32'b00001);
    step();
    clr();

    // Spurious ack on an idle output.
    do_reset();
    switch_ack = 5'b00100;
    settle(); check("E.pop", 32'(pop), 0); check("E.req", 32'(sreq), 0); step();
    settle(); check("E.grant", 32'(ing), 0); step();
    clr();

    // Reset during flit 2 of a 4-flit packet; prio[2] was 4 beforehand, 0 afterwards.
    out_ready = '1; switch_ack = '1; req_tail = '1;
    req_valid = 5'b01000; req_port[3] = 3'd2;
    settle(); step();
    settle(); check("F.pre", 32'(sel[2]), 3); step();
    req_valid = 5'b10000; req_port[4] = 3'd2; req_tail = '0;
    settle(); step();
    settle(); check("F.flit1", 32'(pop), 32'b10000); step();
    settle(); check("F.flit2", 32'(pop), 32'b10000);
    #1 reset_n = 1'b0;
    #1;
    check("F.rst_grant", 32'(ing), 0);
    check("F.rst_req", 32'(sreq), 0);
    check("F.rst_sel", 32'(sel), 0);
    check("F.rst_pop", 32'(pop), 0);
    req_valid = 5'b10010; req_port[1] = 3'd2; req_tail = '1;
    step();
    reset_n = 1'b1;
    settle(); check("F.post_idle", 32'(sreq), 0); step();
    settle(); check("F.prio0", 32'(sel[2]), 1); step();
    clr();

    // Randomized traffic with occasional reset pulses; checked by the model each cycle.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) begin
        req_valid[i]  = ($urandom_range(0, 3) != 0);
        req_port[i]   = PW'($urandom_range(0, NP - 1));
        req_tail[i]   = ($urandom_range(0, 2) == 0);
        out_ready[i]  = ($urandom_range(0, 3) != 0);
        switch_ack[i] = ($urandom_range(0, 3) != 0);
      end
      reset_n = (c % 700 != 350);
      step();
    end
    reset_n = 1'b1;
    clr();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter NUM_PORTS, default 5, router ports (N,E,S,W,Local); PORT_W = $clog2(NUM_PORTS).
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 i_req_valid  in  NUM_PORTS  input unit i has a flit requesting the switch.
REQ-005 i_req_port  in  NUM_PORTS x PORT_W  requested output port per input (routing result).
REQ-006 i_req_tail  in  NUM_PORTS  requesting flit of input i is a tail (or single-flit) flit.
REQ-007 i_out_ready  in  NUM_PORTS  output unit o can accept a flit (port status idle/credit available).
REQ-008 i_switch_ack  in  NUM_PORTS  output unit o accepted the flit this cycle.
REQ-009 o_switch_req  out  NUM_PORTS  switch request to output unit o.
REQ-010 o_xbar_sel  out  NUM_PORTS x PORT_W  crossbar mux select (winning input) per output.
REQ-011 o_in_grant  out  NUM_PORTS  input i currently owns an output; one-hot per input by construction.
REQ-012 o_flit_pop  out  NUM_PORTS  input i shall dequeue its head flit (acked this cycle).

Function
REQ-013 One independent FSM per output o, states SA_IDLE, SA_ACTIVE.
REQ-014 SA_IDLE: candidates = inputs with i_req_valid=1 and i_req_port=o and o_in_grant=0; if any candidate and i_out_ready[o]=1, round-robin pick from prio[o], register owner[o], go SA_ACTIVE next edge.
REQ-015 Arbitration latency: request at edge t -> o_xbar_sel/o_switch_req valid after edge t+1 (one cycle).
REQ-016 Round-robin: search order prio[o], prio[o]+1, ... wrapping at NUM_PORTS-1 -> 0; no starvation.
REQ-017 SA_ACTIVE: o_xbar_sel[o]=owner[o]; o_switch_req[o] = i_out_ready[o] & i_req_valid[owner].
REQ-018 Transfer = o_switch_req[o] & i_switch_ack[o] in same cycle; o_flit_pop[owner] asserted combinationally that cycle.
REQ-019 Packet lock: owner held across i_out_ready or i_req_valid deassertion until tail transfer.
REQ-020 Transfer with i_req_tail[owner]=1: next edge state SA_IDLE, prio[o] = owner+1 mod NUM_PORTS.
REQ-021 After tail release the output spends exactly one cycle in SA_IDLE before the next grant (tail-to-grant gap 1 cycle).
REQ-022 i_switch_ack[o] without o_switch_req[o] ignored; no state change.
REQ-023 Input contention: same input eligible for two outputs in same cycle impossible (single i_req_port); an input with o_in_grant=1 is never a candidate.
REQ-024 Same-cycle multiple outputs granting different inputs permitted (full crossbar parallelism).
REQ-025 In SA_IDLE: o_switch_req[o]=0, o_xbar_sel[o]=0.

Reset
REQ-026 reset_n low: all FSMs SA_IDLE, owner=0, prio=0, o_switch_req=0, o_xbar_sel=0, o_in_grant=0, o_flit_pop=0, immediately (asynchronous).
REQ-027 Reset mid-packet discards lock; after release first arbitration starts from prio=0.
REQ-028 All state registers asynchronously cleared; outputs are registered state or combinational from it, no reset-time glitch.

Structure
REQ-029 router_pkg holds NUM_PORTS, PORT_IDX_t (PORT_W bits), sa_state_t enum {SA_IDLE, SA_ACTIVE}.
REQ-030 Sub-module rr_arbiter (NUM_PORTS requests, prio pointer in, one-hot grant + encoded index out, combinational), instantiated once per output.
REQ-031 Per-output FSM and owner/prio registers in generate loop in switch_allocator.

Verification
REQ-032 Single packet: input 1 requests out 2, 3 flits, ready=1, ack every req -> grant after 1 cycle, o_xbar_sel[2]=1, 3 pops, SA_IDLE after tail, prio[2]=2.
REQ-033 Contention: inputs 0,3,4 request out 1 same cycle, prio[1]=0, single-flit packets -> service order 0,3,4, each separated by 1 idle cycle.
REQ-034 Lock: input 2 owns out 0, i_out_ready[0]=0 for 4 cycles mid-packet while input 3 requests out 0 -> o_switch_req[0]=0, owner stays 2, resumes on ready.
REQ-035 Parallel: inputs 0->3 and 1->4 simultaneously -> both granted same cycle, independent pops.
REQ-036 Spurious ack: i_switch_ack[2]=1 with out 2 idle -> no pop, no state change.
REQ-037 Reset mid-packet: reset_n low during flit 2 of 4 -> all outputs 0 immediately, prio=0 after release.
